chisq_unit_scheduler: RTL and testbench

CHISQ_UNIT_SCHEDULER -- requirements
Module: chisq_unit_scheduler

---
 rtl/chisq_unit_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_chisq_unit_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/chisq_unit_scheduler.sv
// Event scheduler for three chi-square fit units.
// The input side hands each new event to a free unit in round-robin order and
// streams its hit words there. The output side returns results strictly in
// event-issue order, using a small FIFO of unit IDs recorded at assignment.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   ASSIGN | looking for a free unit (search uses registered busy only)
//   STREAM | hit words flow to sel_unit_in until ev_last is seen
module chisq_unit_scheduler (
  input  logic       clock,
  input  logic       reset,
  input  logic       ev_in,
  input  logic       ev_last,
  output logic       in_ready,
  output logic [1:0] sel_unit_in,
  output logic [2:0] unit_start,
  input  logic [2:0] unit_done,
  output logic [2:0] unit_ack,
  output logic [1:0] sel_unit_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] busy,
  output logic       err_done
);

  typedef enum logic {
    ASSIGN = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] rr_q, rr_d;
  logic [1:0] sel_in_q, sel_in_d;
  logic [2:0] start_q, start_d;
  logic [2:0] busy_q, busy_d;
  logic       err_q, err_d;

  // Order queue: unit IDs in the order their events were issued.
  logic [1:0] fifo_q [3];
  logic [1:0] fifo_d [3];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  logic       found;
  logic [1:0] free_unit;
  logic [1:0] cand;
  logic       push;
  logic [1:0] head;
  logic       head_done;
  logic       xfer;

  function automatic logic [2:0] onehot3(input logic [1:0] u);
    case (u)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] u);
    inc3 = (u == 2'd2) ? 2'd0 : u + 2'd1;
  endfunction

  // Round-robin search for a free unit, starting at rr.
  always_comb begin
    found     = 1'b0;
    free_unit = 2'd0;
    cand      = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && ((busy_q & onehot3(cand)) == 3'b000)) begin
        found     = 1'b1;
        free_unit = cand;
      end
      cand = inc3(cand);
    end
  end

  // Queue head and output handshake; no transfer is allowed while reset is
  // asserted so an abandoned result is never acknowledged.
  always_comb begin
    head = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (rd_ptr_q == k[1:0]) head = fifo_q[k];
    end
    head_done = (count_q != 2'd0) && ((unit_done & onehot3(head)) != 3'b000);
    xfer      = head_done && out_ready && !reset;
  end

  // Input FSM next-state and assignment decisions.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    sel_in_d = sel_in_q;
    start_d  = 3'b000;
    push     = 1'b0;
    case (state_q)
      ASSIGN: begin
        if (found) begin
          sel_in_d = free_unit;
          start_d  = onehot3(free_unit);
          push     = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (ev_in && ev_last) begin
          rr_d    = inc3(sel_in_q);
          state_d = ASSIGN;
        end
      end
      default: state_d = ASSIGN;
    endcase
  end

  // Occupancy, order queue and error flag bookkeeping.
  always_comb begin
    busy_d = busy_q;
    if (push) busy_d = busy_d | onehot3(free_unit);
    if (xfer) busy_d = busy_d & ~onehot3(head);

    for (int k = 0; k < 3; k++) begin
      fifo_d[k] = fifo_q[k];
      if (push && (wr_ptr_q == k[1:0])) fifo_d[k] = free_unit;
    end
    wr_ptr_d = push ? inc3(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = xfer ? inc3(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, xfer};

    err_d = err_q | ((unit_done & ~busy_q) != 3'b000);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ASSIGN;
      rr_q     <= 2'd0;
      sel_in_q <= 2'd0;
      start_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      sel_in_q <= sel_in_d;
      start_q  <= start_d;
    end
  end

  // Occupancy, queue and error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= 3'b000;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
      for (int k = 0; k < 3; k++) fifo_q[k] <= 2'd0;
    end else begin
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int k = 0; k < 3; k++) fifo_q[k] <= fifo_d[k];
    end
  end

  assign in_ready     = (state_q == STREAM);
  assign sel_unit_in  = sel_in_q;
  assign unit_start   = start_q;
  assign busy         = busy_q;
  assign err_done     = err_q;
  assign sel_unit_out = (count_q != 2'd0) ? head : 2'd0;
  assign out_valid    = head_done;
  assign unit_ack     = xfer ? onehot3(head) : 3'b000;

  // Structural invariants: selects never 11, pulses one-hot, queue never
  // pushed while full without a simultaneous pop.
  a_sel_in_legal: assert property (@(posedge clock) disable iff (reset)
    sel_unit_in != 2'b11);
  a_sel_out_legal: assert property (@(posedge clock) disable iff (reset)
    sel_unit_out != 2'b11);
  a_start_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(unit_start));
  a_ack_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(unit_ack));
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    push |-> (count_q != 2'd3 || xfer));

endmodule

// File: tb/tb_chisq_unit_scheduler.sv
// Randomized bench for chisq_unit_scheduler. A queue-based reference model
// predicts every output each cycle; simple unit models answer unit_start with
// a done level after a chosen latency and drop it when acknowledged.
module tb_chisq_unit_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ev_in = 1'b0;
  logic       ev_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] unit_done = 3'b000;
  logic       in_ready;
  logic [1:0] sel_unit_in;
  logic [2:0] unit_start;
  logic [2:0] unit_ack;
  logic [1:0] sel_unit_out;
  logic       out_valid;
  logic [2:0] busy;
  logic       err_done;

  chisq_unit_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .ev_in       (ev_in),
    .ev_last     (ev_last),
    .in_ready    (in_ready),
    .sel_unit_in (sel_unit_in),
    .unit_start  (unit_start),
    .unit_done   (unit_done),
    .unit_ack    (unit_ack),
    .sel_unit_out(sel_unit_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_done    (err_done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: which unit is streaming, who is busy, issue order.
  bit       m_stream;
  int       m_sel;
  int       m_rr;
  int       m_start;
  bit [2:0] m_busy;
  int       m_q[$];
  bit       m_err;

  // Unit behaviour and stimulus knobs.
  int  tmr[3];
  bit  dlvl[3];
  bit  inj[3];
  int  lat_min = 5, lat_max = 5;
  bit  hold = 1'b0;
  int  rdy_pct = 100, ev_pct = 80, last_pct = 30;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_stream = 1'b0;
    m_sel    = 0;
    m_rr     = 0;
    m_start  = -1;
    m_busy   = 3'b000;
    m_q.delete();
    m_err    = 1'b0;
  endfunction

  // One clock cycle: drive inputs, compare, advance unit models and the
  // reference model, then move to the next falling edge.
  task automatic step();
    logic [2:0] e_start, e_ack, drv;
    logic [1:0] e_sout;
    logic       e_valid;
    int         head;
    bit         pop;
    int         u;

    drv = 3'b000;
    for (int i = 0; i < 3; i++) drv[i] = dlvl[i] | inj[i];
    unit_done = drv;
    out_ready = ($urandom_range(99) < rdy_pct);
    ev_in     = ($urandom_range(99) < ev_pct);
    ev_last   = ($urandom_range(99) < last_pct);
    #1;

    head    = (m_q.size() > 0) ? m_q[0] : 0;
    e_valid = (m_q.size() > 0) && drv[head];
    pop     = e_valid && out_ready && !reset;
    e_ack   = pop ? (3'b001 << head) : 3'b000;
    e_sout  = 2'(head);
    e_start = (m_start >= 0) ? (3'b001 << m_start) : 3'b000;

    chk("in_ready", in_ready, m_stream);
    chk("sel_unit_in", sel_unit_in, m_sel);
    chk("unit_start", unit_start, e_start);
    chk("busy", busy, m_busy);
    chk("sel_unit_out", sel_unit_out, e_sout);
    chk("out_valid", out_valid, e_valid);
    chk("unit_ack", unit_ack, e_ack);
    chk("err_done", err_done, m_err);

    // Unit behaviour.
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        tmr[i] = 0;
        dlvl[i] = 1'b0;
      end
    end else begin
      if (pop) dlvl[head] = 1'b0;
      if (!hold) begin
        for (int i = 0; i < 3; i++) begin
          if (tmr[i] > 0) begin
            tmr[i]--;
            if (tmr[i] == 0) dlvl[i] = 1'b1;
          end
        end
      end
      if (m_start >= 0) tmr[m_start] = $urandom_range(lat_max, lat_min);
    end

    // Reference model advance.
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) if (drv[i] && !m_busy[i]) m_err = 1'b1;
      m_start = -1;
      if (!m_stream) begin
        for (int k = 0; k < 3; k++) begin
          u = (m_rr + k) % 3;
          if (m_start < 0 && !m_busy[u]) m_start = u;
        end
      end else if (ev_in && ev_last) begin
        m_rr     = (m_sel + 1) % 3;
        m_stream = 1'b0;
      end
      if (pop) begin
        m_busy[head] = 1'b0;
        void'(m_q.pop_front());
      end
      if (m_start >= 0) begin
        m_sel           = m_start;
        m_busy[m_start] = 1'b1;
        m_q.push_back(m_start);
        m_stream        = 1'b1;
      end
    end

    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tmr[i] = 0;
      dlvl[i] = 1'b0;
      inj[i] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    model_reset();
    do_reset(2);

    // Fixed 5-cycle latency, downstream always ready.
    lat_min = 5; lat_max = 5; rdy_pct = 100; ev_pct = 100; last_pct = 40;
    run(60);

    // All units stuck without done, then released.
    do_reset(1);
    hold = 1'b1; rdy_pct = 70; last_pct = 60;
    run(40);
    hold = 1'b0; lat_min = 1; lat_max = 3;
    run(40);

    // Long back-pressure stretch followed by release.
    rdy_pct = 0; lat_min = 1; lat_max = 2;
    run(25);
    rdy_pct = 100;
    run(20);

    // Random latencies and back-pressure with resets dropped mid-traffic.
    lat_min = 1; lat_max = 12; rdy_pct = 60; ev_pct = 70; last_pct = 25;
    run(300);
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(80, 15));
      do_reset(1);
    end
    run(200);

    // Done from an idle unit right after reset must raise the sticky error.
    do_reset(1);
    inj[2] = 1'b1;
    step();
    inj[2] = 1'b0;
    run(60);
    do_reset(1);
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
